uart_tx: RTL

//  Serial UART transmitter; the transmit-side counterpart of the pipeline's UART receiver.

---
 rtl/uart_tx_pkg.sv | 17 +
 rtl/uart_tx_if.sv | 23 ++
 rtl/uart_tx.sv | 121 ++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding, oversampling
// factor and frame-format defaults.
package uart_tx_pkg;

    localparam int OVERSAMPLE  = 16;
    localparam int DIN_W       = 8;
    localparam int DBIT_DEF    = 8;
    localparam int SB_TICK_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// Host-side handshake of the UART transmitter: request, word, baud tick in;
// serial line and status out.
interface uart_tx_if;
    import uart_tx_pkg::*;

    logic             tx_start;
    logic             s_tick;
    logic [DIN_W-1:0] din;
    logic             tx_done_tick;
    logic             tx_busy;
    logic             tx;

    modport master (
        output tx_start, s_tick, din,
        input  tx_done_tick, tx_busy, tx
    );

    modport slave (
        input  tx_start, s_tick, din,
        output tx_done_tick, tx_busy, tx
    );

endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB-first, SB_TICK ticks of stop,
// paced by a 16x oversampling tick; all outputs come straight from flops.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int DBIT    = DBIT_DEF,
    parameter int SB_TICK = SB_TICK_DEF
) (
    input  logic     clk,
    input  logic     reset,
    uart_tx_if.slave bus
);

    localparam logic [4:0] S_LAST  = 5'(OVERSAMPLE - 1);
    localparam logic [4:0] SB_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] N_LAST  = 3'(DBIT - 1);

    tx_state_t        r_state;
    tx_state_t        w_state_nxt;
    logic [4:0]       r_s;
    logic [4:0]       w_s_nxt;
    logic [2:0]       r_n;
    logic [2:0]       w_n_nxt;
    logic [DIN_W-1:0] r_shift;
    logic [DIN_W-1:0] w_shift_nxt;
    logic             r_tx;
    logic             w_tx_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_n     <= w_n_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_n_nxt     = r_n;
        w_shift_nxt = r_shift;
        w_done_nxt  = 1'b0;
        case (r_state)
            // Acceptance ignores s_tick; the start bit counts from the next tick.
            ST_IDLE: begin
                if (bus.tx_start) begin
                    w_state_nxt = ST_START;
                    w_s_nxt     = '0;
                    w_shift_nxt = bus.din;
                end
            end
            ST_START: begin
                if (bus.s_tick) begin
                    if (r_s == S_LAST) begin
                        w_state_nxt = ST_DATA;
                        w_s_nxt     = '0;
                        w_n_nxt     = '0;
                    end else begin
                        w_s_nxt = r_s + 5'd1;
                    end
                end
            end
            ST_DATA: begin
                if (bus.s_tick) begin
                    if (r_s == S_LAST) begin
                        w_s_nxt     = '0;
                        w_shift_nxt = r_shift >> 1;
                        if (r_n == N_LAST) begin
                            w_state_nxt = ST_STOP;
                        end else begin
                            w_n_nxt = r_n + 3'd1;
                        end
                    end else begin
                        w_s_nxt = r_s + 5'd1;
                    end
                end
            end
            ST_STOP: begin
                if (bus.s_tick) begin
                    if (r_s == SB_LAST) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_s_nxt = r_s + 5'd1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Line level follows the state being entered, so tx moves on the same edge as the FSM.
    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            ST_START: w_tx_nxt = 1'b0;
            ST_DATA:  w_tx_nxt = w_shift_nxt[0];
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    assign bus.tx           = r_tx;
    assign bus.tx_done_tick = r_done;
    assign bus.tx_busy      = r_busy;

endmodule
